// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S receive path: frame-tracking states,
// default frame geometry and a constant-friendly ceil(log2) helper.
package i2s_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

  localparam int DEF_DATA_WIDTH = 24;
  localparam int DEF_SLOT_BITS  = 32;
  localparam int DEF_I2S_DELAY  = 1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/i2s_slot_counter.sv
// BCLK position tracker: owns the frame bit counter and decodes, for the
// current BCLK pulse, whether it lands in a capture window and which slot.
module i2s_slot_counter
  import i2s_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int SLOT_BITS  = DEF_SLOT_BITS,
  parameter int I2S_DELAY  = DEF_I2S_DELAY,
  localparam int BW        = clog2(2 * SLOT_BITS) + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic bclk_rise,
  input  logic lrclk_rise,
  input  logic run,
  output logic shift_en,
  output logic right_last,
  output logic left_last,
  output logic frame_full,
  output logic overflow
);

  localparam logic [BW-1:0] SLOT  = BW'(SLOT_BITS);
  localparam logic [BW-1:0] FRAME = BW'(2 * SLOT_BITS);
  localparam logic [BW-1:0] DLY   = BW'(I2S_DELAY);
  localparam logic [BW-1:0] WID   = BW'(DATA_WIDTH);
  localparam logic [BW-1:0] WLAST = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] ONE   = BW'(1);

  logic [BW-1:0] bcnt;
  logic [BW-1:0] idx;
  logic [BW-1:0] pos;
  logic [BW-1:0] rel;
  logic          bit_en;
  logic          right_sel;
  logic          in_win;
  logic          last_bit;

  // A coincident LRCLK pulse restarts the frame, so this BCLK is bit 0.
  // rel wraps to a large value when pos < DLY, keeping it outside the window.
  always_comb begin
    idx        = lrclk_rise ? '0 : bcnt;
    bit_en     = bclk_rise && (run || lrclk_rise);
    right_sel  = idx < SLOT;
    pos        = right_sel ? idx : idx - SLOT;
    rel        = pos - DLY;
    in_win     = (idx < FRAME) && (rel < WID);
    last_bit   = (rel == WLAST);
    shift_en   = bit_en && in_win;
    right_last = shift_en && last_bit && right_sel;
    left_last  = shift_en && last_bit && !right_sel;
    frame_full = (bcnt == FRAME);
    overflow   = run && bclk_rise && !lrclk_rise && frame_full;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt <= '0;
    end else if (lrclk_rise) begin
      bcnt <= bclk_rise ? ONE : '0;
    end else if (run && bclk_rise) begin
      bcnt <= bcnt + ONE;
    end
  end

endmodule

// File: rtl/i2s_rx_deserializer.sv
// I2S frame reassembler: HUNT = waiting for an LRCLK edge to align on,
// LOCK = counting BCLKs, capturing right/left words and pairing them.
module i2s_rx_deserializer
  import i2s_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int SLOT_BITS  = DEF_SLOT_BITS,
  parameter int I2S_DELAY  = DEF_I2S_DELAY
) (
  input  logic                  MCLK,
  input  logic                  RST,
  input  logic                  SDATA,
  input  logic                  BCLK_RISE,
  input  logic                  LRCLK_RISE,
  output logic [DATA_WIDTH-1:0] DOUT_L,
  output logic [DATA_WIDTH-1:0] DOUT_R,
  output logic                  DVALID,
  output logic                  LOCKED,
  output logic                  SYNC_ERR
);

  if (DATA_WIDTH + I2S_DELAY > SLOT_BITS) begin : g_bad_cfg
    $fatal(1, "i2s_rx_deserializer: DATA_WIDTH + I2S_DELAY exceeds SLOT_BITS");
  end

  state_t                state;
  logic                  run;
  logic                  shift_en;
  logic                  right_last;
  logic                  left_last;
  logic                  frame_full;
  logic                  overflow;
  logic                  resync;
  logic                  right_ok;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] shreg_next;
  logic [DATA_WIDTH-1:0] hold_r;

  assign run = (state == LOCK);

  i2s_slot_counter #(
    .DATA_WIDTH (DATA_WIDTH),
    .SLOT_BITS  (SLOT_BITS),
    .I2S_DELAY  (I2S_DELAY)
  ) u_slot (
    .clk        (MCLK),
    .rst        (RST),
    .bclk_rise  (BCLK_RISE),
    .lrclk_rise (LRCLK_RISE),
    .run        (run),
    .shift_en   (shift_en),
    .right_last (right_last),
    .left_last  (left_last),
    .frame_full (frame_full),
    .overflow   (overflow)
  );

  // An early LRCLK drops the partial word before any coincident bit shifts in.
  always_comb begin
    resync     = run && LRCLK_RISE && !frame_full;
    shreg_next = resync ? '0 : shreg;
    if (shift_en) shreg_next = (shreg_next << 1) | DATA_WIDTH'(SDATA);
  end

  always_ff @(posedge MCLK or posedge RST) begin
    if (RST) begin
      state    <= HUNT;
      shreg    <= '0;
      hold_r   <= '0;
      right_ok <= 1'b0;
      DOUT_L   <= '0;
      DOUT_R   <= '0;
      DVALID   <= 1'b0;
      LOCKED   <= 1'b0;
      SYNC_ERR <= 1'b0;
    end else begin
      DVALID   <= 1'b0;
      SYNC_ERR <= 1'b0;
      shreg    <= shreg_next;
      case (state)
        HUNT: begin
          right_ok <= 1'b0;
          if (LRCLK_RISE) begin
            state  <= LOCK;
            LOCKED <= 1'b1;
          end
        end
        LOCK: begin
          if (overflow) begin
            state    <= HUNT;
            LOCKED   <= 1'b0;
            SYNC_ERR <= 1'b1;
            right_ok <= 1'b0;
          end else begin
            if (resync) SYNC_ERR <= 1'b1;
            if (LRCLK_RISE) right_ok <= 1'b0;
            if (right_last) begin
              hold_r   <= shreg_next;
              right_ok <= 1'b1;
            end
            // Only a right word from this same frame may be paired.
            if (left_last) begin
              right_ok <= 1'b0;
              if (right_ok) begin
                DOUT_L <= shreg_next;
                DOUT_R <= hold_r;
                DVALID <= 1'b1;
              end
            end
          end
        end
        default: begin
          state  <= HUNT;
          LOCKED <= 1'b0;
        end
      endcase
    end
  end

endmodule
